// File: rtl/cache_pkg.sv
// Shared cache/memory types: line type, memory-responder states, default geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

   // Default geometry shared with the cache: 32-byte lines, 256-bit line bus.
   localparam int S_OFFSET = 5;
   localparam int S_LINE   = 8 * (2 ** S_OFFSET);

   typedef logic [S_LINE-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP,
      RECOVER
   } mem_state_e;

endpackage

// File: rtl/line_mem_array.sv
// Single-port line RAM with per-byte write enable and a registered read port.
// Latency: read data appears one clock after re; writes land on the same edge.
// Backpressure: none; one access per enabled cycle, no reset on storage or read register.
//
// Ports: clk; addr (line index); we/be/wdata (masked line write);
//        re (capture line into rdata); rdata (holds until the next re).
module line_mem_array
   import cache_pkg::*;
#(
   parameter int s_offset = S_OFFSET,
   parameter int s_line   = S_LINE,
   parameter int s_depth  = 10
) (
   input  logic                   clk,
   input  logic [s_depth-1:0]     addr,
   input  logic                   we,
   input  logic                   re,
   input  logic [2**s_offset-1:0] be,
   input  logic [s_line-1:0]      wdata,
   output logic [s_line-1:0]      rdata
);

   logic [s_line-1:0] mem_q [2**s_depth];
   logic [s_line-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 2**s_offset; b++) begin
            if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/cache_line_memory.sv
// Line-granular backing memory answering the cache's memory-side port.
// Latency: mem_resp rises LATENCY edges after acceptance; next accept LATENCY+2 edges later.
// Backpressure: requester holds mem_read/mem_write until mem_resp; an early drop aborts.
//
// Ports: clk, rst (async, active-low); mem_address/mem_read/mem_write/
//        mem_byte_enable/mem_wdata (request); mem_rdata/mem_resp (completion);
//        error (sticky protocol-violation flag, cleared only by reset).
module cache_line_memory
   import cache_pkg::*;
#(
   parameter int s_offset = S_OFFSET,
   parameter int s_line   = S_LINE,
   parameter int s_depth  = 10,
   parameter int LATENCY  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            mem_address,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic [2**s_offset-1:0] mem_byte_enable,
   input  logic [s_line-1:0]      mem_wdata,
   output logic [s_line-1:0]      mem_rdata,
   output logic                   mem_resp,
   output logic                   error
);

   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   mem_state_e               state_q, state_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [s_depth-1:0]       addr_q, addr_d;
   logic                     op_wr_q, op_wr_d;
   logic [s_line-1:0]        wdata_q, wdata_d;
   logic [2**s_offset-1:0]   be_q, be_d;
   logic                     resp_q, resp_d;
   logic                     err_q, err_d;
   logic                     rd_vld_q, rd_vld_d;

   logic                     held;
   logic                     fire;
   logic [s_line-1:0]        arr_rdata;

   // Offset and upper address bits carry no meaning here; upper bits wrap.
   logic unused_addr;
   assign unused_addr = ^{mem_address[31:s_offset+s_depth], mem_address[s_offset-1:0]};

   // The latched op decides which strobe must stay asserted for the access.
   assign held = op_wr_q ? mem_write : mem_read;
   assign fire = (state_q == BUSY) && (cnt_q == 8'd0) && held;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      op_wr_d  = op_wr_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      resp_d   = 1'b0;
      err_d    = err_q;
      rd_vld_d = rd_vld_q;
      case (state_q)
         // RECOVER is the low turnaround cycle after RESP; a request presented
         // during it is latched on its closing edge, giving LATENCY+2 spacing.
         IDLE, RECOVER: begin
            state_d = IDLE;
            if (mem_read || mem_write) begin
               addr_d  = mem_address[s_offset +: s_depth];
               op_wr_d = mem_write;
               wdata_d = mem_wdata;
               be_d    = mem_byte_enable;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
               if (mem_read && mem_write) err_d = 1'b1;
            end
         end
         BUSY: begin
            if (!held) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
               err_d   = 1'b1;
            end else if (cnt_q == 8'd0) begin
               state_d = RESP;
               resp_d  = 1'b1;
               if (!op_wr_q) rd_vld_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         // The finished request is still held during RESP and is ignored.
         RESP:    state_d = RECOVER;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         addr_q   <= '0;
         op_wr_q  <= 1'b0;
         wdata_q  <= '0;
         be_q     <= '0;
         resp_q   <= 1'b0;
         err_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         op_wr_q  <= op_wr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         resp_q   <= resp_d;
         err_q    <= err_d;
         rd_vld_q <= rd_vld_d;
      end
   end

   line_mem_array #(
      .s_offset (s_offset),
      .s_line   (s_line),
      .s_depth  (s_depth)
   ) u_array (
      .clk   (clk),
      .addr  (addr_q),
      .we    (fire && op_wr_q),
      .re    (fire && !op_wr_q),
      .be    (be_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   // The RAM read register has no reset; until a read completes after reset
   // the output is forced to zero.
   assign mem_rdata = rd_vld_q ? arr_rdata : '0;
   assign mem_resp  = resp_q;
   assign error     = err_q;

endmodule

// File: tb/tb_cache_line_memory.sv
module tb_cache_line_memory;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] addr = '0, addr1 = 32'h20;
   logic        rd = 1'b0, wr = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
   logic [31:0] be = '0, be1 = '0;
   line_t       wdata = '0, wdata1 = '0;
   line_t       rdata, rdata1;
   logic        resp, resp1, err, err1;

   int    errors = 0;
   int    checks = 0;
   line_t last_rd = '0;

   cache_line_memory #(.LATENCY(4)) u_dut (
      .clk(clk), .rst(rst_n), .mem_address(addr), .mem_read(rd), .mem_write(wr),
      .mem_byte_enable(be), .mem_wdata(wdata), .mem_rdata(rdata),
      .mem_resp(resp), .error(err)
   );

   cache_line_memory #(.LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst_n), .mem_address(addr1), .mem_read(rd1), .mem_write(wr1),
      .mem_byte_enable(be1), .mem_wdata(wdata1), .mem_rdata(rdata1),
      .mem_resp(resp1), .error(err1)
   );

   // Full handshake on the LATENCY=4 instance: latency, pulse width, and
   // for writes that the read line is left untouched.
   task automatic do_req(input logic do_rd, input logic do_wr, input logic [31:0] a,
                         input line_t d, input logic [31:0] m, input string name);
      int lat;
      @(negedge clk);
      addr = a; rd = do_rd; wr = do_wr; wdata = d; be = m;
      @(posedge clk);
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (resp) begin lat = c; break; end
      end
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL %s latency: got %0d want 4 (0 = no resp)", name, lat);
      end
      if (do_wr) begin
         checks++;
         if (rdata !== last_rd) begin
            errors++;
            $display("FAIL %s rdata_kept: got %h want %h", name, rdata, last_rd);
         end
      end
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (resp !== 1'b0) begin
         errors++;
         $display("FAIL %s resp_width: got %b want 0", name, resp);
      end
   endtask

   task automatic write_line(input logic [31:0] a, input line_t d, input logic [31:0] m,
                             input string name);
      do_req(1'b0, 1'b1, a, d, m, name);
   endtask

   task automatic read_line(input logic [31:0] a, input line_t exp, input string name);
      do_req(1'b1, 1'b0, a, '0, '0, name);
      checks++;
      if (rdata !== exp) begin
         errors++;
         $display("FAIL %s rdata: got %h want %h", name, rdata, exp);
      end
      last_rd = exp;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (resp  !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b want 0", resp); end
      checks++; if (rdata !== '0)   begin errors++; $display("FAIL rst_rdata: got %h want 0", rdata); end
      checks++; if (err   !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", err); end
      checks++; if (resp1 !== 1'b0) begin errors++; $display("FAIL rst_resp1: got %b want 0", resp1); end
      checks++; if (err1  !== 1'b0) begin errors++; $display("FAIL rst_error1: got %b want 0", err1); end
      @(negedge clk);
      rst_n = 1'b1;
      last_rd = '0;
   endtask

   task automatic test_write_read();
      write_line(32'h40, {32{8'hA5}}, 32'hFFFF_FFFF, "wr_40");
      read_line(32'h40, {32{8'hA5}}, "rd_40");
   endtask

   task automatic test_byte_mask();
      write_line(32'h80, {32{8'h11}}, 32'hFFFF_FFFF, "wr_80_full");
      write_line(32'h80, {32{8'hFF}}, 32'h0000_000F, "wr_80_mask");
      read_line(32'h80, {{28{8'h11}}, 32'hFFFF_FFFF}, "rd_80_mask");
   endtask

   task automatic test_wrap();
      write_line(32'h0, {32{8'h5A}}, 32'hFFFF_FFFF, "wr_0");
      read_line(32'h0, {32{8'h5A}}, "rd_0");
      read_line(32'h8000, {32{8'h5A}}, "rd_8000_wrap");
      read_line(32'h1F, {32{8'h5A}}, "rd_1f_offset");
      read_line(32'h40, {32{8'hA5}}, "rd_40_intact");
   endtask

   task automatic test_back_to_back();
      logic want;
      @(negedge clk);
      rd1 = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         want = ((i % 3) == 1);
         checks++;
         if (resp1 !== want) begin
            errors++;
            $display("FAIL b2b_resp[%0d]: got %b want %b", i, resp1, want);
         end
      end
      @(negedge clk);
      rd1 = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_abort();
      logic seen;
      write_line(32'hC0, {32{8'h33}}, 32'hFFFF_FFFF, "wr_c0");
      @(negedge clk);
      addr = 32'hC0; wr = 1'b1; wdata = {32{8'h44}}; be = 32'hFFFF_FFFF;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      wr = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (resp) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_resp: got %b want 0", seen); end
      checks++; if (err  !== 1'b1) begin errors++; $display("FAIL abort_error: got %b want 1", err); end
      read_line(32'hC0, {32{8'h33}}, "rd_c0_unchanged");
      checks++; if (err  !== 1'b1) begin errors++; $display("FAIL abort_sticky: got %b want 1", err); end
   endtask

   task automatic test_reset_mid_write();
      write_line(32'h100, {32{8'h55}}, 32'hFFFF_FFFF, "wr_100");
      @(negedge clk);
      addr = 32'h100; wr = 1'b1; wdata = {32{8'h66}}; be = 32'hFFFF_FFFF;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (resp !== 1'b0) begin errors++; $display("FAIL rstmid_resp: got %b want 0", resp); end
      wr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstmid_error: got %b want 0", err); end
      @(negedge clk);
      rst_n = 1'b1;
      last_rd = '0;
      read_line(32'h100, {32{8'h55}}, "rd_100_unchanged");
   endtask

   task automatic test_reset_in_resp();
      logic got;
      @(negedge clk);
      addr = 32'h40; rd = 1'b1;
      @(posedge clk);
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (resp) begin got = 1'b1; break; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rstresp_seen: got %b want 1", got); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (resp  !== 1'b0) begin errors++; $display("FAIL rstresp_async: got %b want 0", resp); end
      checks++; if (rdata !== '0)   begin errors++; $display("FAIL rstresp_rdata: got %h want 0", rdata); end
      rd = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      last_rd = '0;
   endtask

   task automatic test_rw_conflict();
      do_req(1'b1, 1'b1, 32'h140, {32{8'h77}}, 32'hFFFF_FFFF, "rw_140");
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL rw_error: got %b want 1", err); end
      read_line(32'h140, {32{8'h77}}, "rd_140");
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_mask();
      test_wrap();
      test_back_to_back();
      test_abort();
      test_reset_mid_write();
      test_reset_in_resp();
      test_rw_conflict();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
